// File: rtl/fifo_scheduler.sv
// Round-robin write arbiter and chunked read sequencer wrapped around the
// width-converting fifo_memory; presents narrow chunks downstream with valid/ready/last.
module fifo_scheduler #(
  parameter int N_REQ          = 4,
  parameter int DATA_IN_WIDTH  = 16,
  parameter int DATA_OUT_WIDTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [N_REQ-1:0]                 req,
  input  logic [N_REQ*DATA_IN_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]                 grant,
  output logic                             fifo_wr_en,
  output logic [DATA_IN_WIDTH-1:0]         fifo_data_in,
  input  logic                             fifo_full,
  output logic                             fifo_rd_en,
  input  logic [DATA_OUT_WIDTH-1:0]        fifo_data_out,
  input  logic                             fifo_empty,
  output logic                             out_valid,
  output logic [DATA_OUT_WIDTH-1:0]        out_data,
  output logic                             out_last,
  input  logic                             out_ready
);

  localparam int CHUNK_COUNT = DATA_IN_WIDTH / DATA_OUT_WIDTH;
  localparam int CNT_W       = $clog2(CHUNK_COUNT);
  localparam int PTR_W       = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, VALID, SETTLE} state_t;

  logic [PTR_W-1:0]         rr_ptr;
  logic [PTR_W-1:0]         win;
  logic [PTR_W:0]           cand;
  logic                     found;
  logic [DATA_IN_WIDTH-1:0] wr_data;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         chunk_cnt, chunk_cnt_nxt;
  logic                     is_last;

  // Circular search starting at rr_ptr; cand carries one extra bit so the
  // wrap can be folded back for non-power-of-two requester counts.
  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    cand  = '0;
    if (en && !fifo_full) begin
      for (int k = 0; k < N_REQ; k++) begin
        cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
        if (cand >= (PTR_W+1)'(N_REQ)) cand = cand - (PTR_W+1)'(N_REQ);
        if (!found && req[cand[PTR_W-1:0]]) begin
          found = 1'b1;
          win   = cand[PTR_W-1:0];
        end
      end
    end
    if (found) grant[win] = 1'b1;
  end

  always_comb begin
    wr_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) wr_data = req_data[i*DATA_IN_WIDTH +: DATA_IN_WIDTH];
    end
  end

  assign fifo_wr_en   = found;
  assign fifo_data_in = wr_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (found) begin
      rr_ptr <= (win == PTR_W'(N_REQ-1)) ? '0 : win + 1'b1;
    end
  end

  // Read sequencer: fifo_data_out is registered, so a read issued in one
  // cycle is presented in VALID the next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      chunk_cnt <= '0;
    end else begin
      state     <= state_nxt;
      chunk_cnt <= chunk_cnt_nxt;
    end
  end

  assign is_last = (chunk_cnt == CNT_W'(CHUNK_COUNT-1));

  always_comb begin
    state_nxt     = state;
    chunk_cnt_nxt = chunk_cnt;
    fifo_rd_en    = 1'b0;
    out_valid     = 1'b0;
    out_last      = 1'b0;
    case (state)
      IDLE: begin
        if (en && !fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_nxt  = VALID;
        end
      end
      VALID: begin
        out_valid = 1'b1;
        out_last  = is_last;
        if (out_ready) begin
          if (is_last) begin
            chunk_cnt_nxt = '0;
            state_nxt     = SETTLE;
          end else begin
            chunk_cnt_nxt = chunk_cnt + 1'b1;
            if (en && !fifo_empty) fifo_rd_en = 1'b1;
            else                   state_nxt  = IDLE;
          end
        end
      end
      SETTLE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign out_data = fifo_data_out;

endmodule

// File: tb/tb_fifo_scheduler.sv
// Directed bench for fifo_scheduler with a small behavioural width-converting
// FIFO (16-bit words in, 4-bit chunks out, low chunk first).
module tb_fifo_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic [3:0]  grant;
  logic        fifo_wr_en;
  logic [15:0] fifo_data_in;
  logic        fifo_full;
  logic        fifo_rd_en;
  logic [3:0]  fifo_data_out;
  logic        fifo_empty;
  logic        out_valid;
  logic [3:0]  out_data;
  logic        out_last;
  logic        out_ready;

  logic        capture;
  logic [15:0] q[$];
  logic [15:0] head;
  int          rch;

  int errors = 0;
  int checks = 0;

  fifo_scheduler #(.N_REQ(4), .DATA_IN_WIDTH(16), .DATA_OUT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .req_data(req_data),
    .grant(grant), .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .fifo_full(fifo_full), .fifo_rd_en(fifo_rd_en), .fifo_data_out(fifo_data_out),
    .fifo_empty(fifo_empty), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: pops a word once its last chunk has been read.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      rch = 0;
      fifo_data_out <= '0;
      fifo_empty    <= 1'b1;
    end else begin
      if (fifo_rd_en && q.size() > 0) begin
        head = q[0];
        fifo_data_out <= head[rch*4 +: 4];
        if (rch == 3) begin
          void'(q.pop_front());
          rch = 0;
        end else begin
          rch++;
        end
      end
      if (fifo_wr_en && capture) q.push_back(fifo_data_in);
      fifo_empty <= (q.size() == 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; req = 4'b0000; req_data = '0;
    fifo_full = 1'b0; out_ready = 1'b0; capture = 1'b0;
    repeat (3) cyc();
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_data_in", 32'(fifo_data_in), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);

    // Idle after reset release
    cyc(); rst = 1'b1; en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cyc(); #1;
      check("idle_grant", 32'(grant), 32'd0);
      check("idle_wr_en", 32'(fifo_wr_en), 32'd0);
      check("idle_out_valid", 32'(out_valid), 32'd0);
      check("idle_rd_en", 32'(fifo_rd_en), 32'd0);
    end

    // Round-robin with all requesters active
    req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    cyc(); req = 4'b1111; #1;
    check("rr_grant0", 32'(grant), 32'b0001); check("rr_data0", 32'(fifo_data_in), 32'h1111);
    check("rr_wr_en", 32'(fifo_wr_en), 32'd1);
    cyc(); #1;
    check("rr_grant1", 32'(grant), 32'b0010); check("rr_data1", 32'(fifo_data_in), 32'h2222);
    cyc(); #1;
    check("rr_grant2", 32'(grant), 32'b0100); check("rr_data2", 32'(fifo_data_in), 32'h3333);
    cyc(); #1;
    check("rr_grant3", 32'(grant), 32'b1000); check("rr_data3", 32'(fifo_data_in), 32'h4444);
    cyc(); #1;
    check("rr_grant4", 32'(grant), 32'b0001); check("rr_data4", 32'(fifo_data_in), 32'h1111);

    // en low blocks grants; rr_ptr is now 1
    cyc(); req = 4'b0001; en = 1'b0; #1;
    check("en_low_grant", 32'(grant), 32'd0);
    check("en_low_wr_en", 32'(fifo_wr_en), 32'd0);

    // FIFO full blocks grants and leaves rr_ptr at 1
    cyc(); en = 1'b1; fifo_full = 1'b1; req = 4'b0101; #1;
    check("full_grant_a", 32'(grant), 32'd0);
    check("full_wr_en", 32'(fifo_wr_en), 32'd0);
    check("full_data_in", 32'(fifo_data_in), 32'd0);
    cyc(); #1;
    check("full_grant_b", 32'(grant), 32'd0);
    cyc(); fifo_full = 1'b0; #1;
    check("unfull_grant", 32'(grant), 32'b0100);
    check("unfull_data", 32'(fifo_data_in), 32'h3333);
    cyc(); #1;
    check("unfull_next", 32'(grant), 32'b0001);
    check("unfull_next_data", 32'(fifo_data_in), 32'h1111);

    // Word 16'hABCD streamed as D,C,B,A; rr_ptr is 1
    cyc(); req = 4'b0001; req_data[15:0] = 16'hABCD; capture = 1'b1; out_ready = 1'b1; #1;
    check("abcd_grant", 32'(grant), 32'b0001);
    check("abcd_data_in", 32'(fifo_data_in), 32'hABCD);
    cyc(); req = 4'b0000; #1;
    check("abcd_rd0", 32'(fifo_rd_en), 32'd1);
    check("abcd_valid0", 32'(out_valid), 32'd0);
    cyc(); #1;
    check("abcd_v_d", 32'(out_valid), 32'd1); check("abcd_d", 32'(out_data), 32'hD);
    check("abcd_last_d", 32'(out_last), 32'd0); check("abcd_rd_d", 32'(fifo_rd_en), 32'd1);
    cyc(); #1;
    check("abcd_c", 32'(out_data), 32'hC); check("abcd_last_c", 32'(out_last), 32'd0);
    check("abcd_rd_c", 32'(fifo_rd_en), 32'd1);
    cyc(); #1;
    check("abcd_b", 32'(out_data), 32'hB); check("abcd_last_b", 32'(out_last), 32'd0);
    check("abcd_rd_b", 32'(fifo_rd_en), 32'd1);
    cyc(); #1;
    check("abcd_a", 32'(out_data), 32'hA); check("abcd_last_a", 32'(out_last), 32'd1);
    check("abcd_v_a", 32'(out_valid), 32'd1); check("abcd_rd_a", 32'(fifo_rd_en), 32'd0);
    cyc(); #1;
    check("settle_valid", 32'(out_valid), 32'd0); check("settle_rd", 32'(fifo_rd_en), 32'd0);
    cyc(); #1;
    check("post_idle_valid", 32'(out_valid), 32'd0); check("post_idle_rd", 32'(fifo_rd_en), 32'd0);

    // Backpressure mid-word on 16'h9876; rr_ptr is 1
    cyc(); req = 4'b0010; req_data[31:16] = 16'h9876; out_ready = 1'b0; #1;
    check("bp_grant", 32'(grant), 32'b0010);
    cyc(); req = 4'b0000; #1;
    check("bp_rd0", 32'(fifo_rd_en), 32'd1);
    cyc(); out_ready = 1'b1; #1;
    check("bp_6", 32'(out_data), 32'h6); check("bp_rd_6", 32'(fifo_rd_en), 32'd1);
    cyc(); out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", 32'(out_data), 32'h7);
      check("bp_hold_rd", 32'(fifo_rd_en), 32'd0);
      check("bp_hold_last", 32'(out_last), 32'd0);
      cyc();
    end
    out_ready = 1'b1; #1;
    check("bp_7", 32'(out_data), 32'h7); check("bp_rd_7", 32'(fifo_rd_en), 32'd1);
    cyc(); #1;
    check("bp_8", 32'(out_data), 32'h8); check("bp_last_8", 32'(out_last), 32'd0);
    cyc(); #1;
    check("bp_9", 32'(out_data), 32'h9); check("bp_last_9", 32'(out_last), 32'd1);
    check("bp_rd_9", 32'(fifo_rd_en), 32'd0);
    cyc(); #1;
    check("bp_settle_valid", 32'(out_valid), 32'd0); check("bp_settle_rd", 32'(fifo_rd_en), 32'd0);
    cyc();

    // Async reset while a chunk is presented; rr_ptr is 2
    req = 4'b0100; req_data[47:32] = 16'h4321; out_ready = 1'b0; #1;
    check("ar_grant", 32'(grant), 32'b0100);
    cyc(); req = 4'b0000; #1;
    check("ar_rd0", 32'(fifo_rd_en), 32'd1);
    cyc(); out_ready = 1'b1; #1;
    check("ar_1", 32'(out_data), 32'h1);
    cyc(); out_ready = 1'b0; #1;
    check("ar_2", 32'(out_data), 32'h2); check("ar_valid_pre", 32'(out_valid), 32'd1);
    #2 rst = 1'b0; #1;
    check("ar_valid_async", 32'(out_valid), 32'd0);
    check("ar_rd_async", 32'(fifo_rd_en), 32'd0);
    cyc(); cyc(); rst = 1'b1; #1;
    check("ar_post_valid", 32'(out_valid), 32'd0);
    check("ar_post_rd", 32'(fifo_rd_en), 32'd0);

    // rr_ptr and chunk_cnt restart from 0
    cyc(); req = 4'b1111; req_data[15:0] = 16'hFEDC; #1;
    check("ar_rr_grant", 32'(grant), 32'b0001);
    check("ar_rr_data", 32'(fifo_data_in), 32'hFEDC);
    cyc(); req = 4'b0000; out_ready = 1'b1; #1;
    check("ar_rd1", 32'(fifo_rd_en), 32'd1);
    cyc(); #1;
    check("ar_c", 32'(out_data), 32'hC); check("ar_last_c", 32'(out_last), 32'd0);
    cyc(); #1;
    check("ar_d", 32'(out_data), 32'hD); check("ar_last_d", 32'(out_last), 32'd0);
    cyc(); #1;
    check("ar_e", 32'(out_data), 32'hE); check("ar_last_e", 32'(out_last), 32'd0);
    cyc(); #1;
    check("ar_f", 32'(out_data), 32'hF); check("ar_last_f", 32'(out_last), 32'd1);
    cyc(); #1;
    check("ar_settle", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
